mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage between the ALU and register writeback. Takes the ALU result, the opcode, rs2 and destination register, and issues a single-beat load or store on the data-memory handshake. Formats load data with sign or zero extension and presents one writeback record per accepted instruction. Non-memory results pass through with one cycle of latency; misaligned accesses and memory timeouts are flagged instead of issued.

## Interface
- WIDTH, 32: datapath width.
- TIMEOUT, 15: maximum number of cycles to wait for mem_ready before an error is flagged.

- clk  in  1  clock. One clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  input record valid.
- ready_out  out  1  stage can accept; high only in IDLE.
- instr_in  in  6  opcode, using the `i_*` encodings from instructions.v.
- alu_out  in  WIDTH  ALU result: address for loads/stores, value otherwise.
- rs2  in  WIDTH  store data.
- rd  in  5  destination register.
- pc  in  32  instruction PC.
- mem_req  out  1  memory request.
- mem_we  out  1  1 for store.
- mem_addr  out  32  word-aligned address ({alu_out[31:2],2'b00}).
- mem_wdata  out  32  lane-shifted store data.
- mem_wstrb  out  4  byte enables.
- mem_ready  in  1  memory completes the request this cycle; rdata is valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse per retired record.
- wb_we  out  1  register write enable.
- wb_rd  out  5  destination register.
- wb_data  out  WIDTH  write value.
- err_misalign  out  1  pulse, concurrent with wb_valid.
- err_timeout  out  1  pulse, concurrent with wb_valid.

## Operation
- States: IDLE, MEM, DONE.
- IDLE:
  - When valid_in is high, capture instr_in, alu_out, rs2, rd and pc.
  - Non-memory op or misaligned access: go to DONE.
  - Aligned load or store: go to MEM.
- MEM:
  - mem_req is held high, and mem_addr, mem_we, mem_wdata and mem_wstrb are held stable.
  - When mem_ready is sampled high: capture mem_rdata, then go to DONE.
  - A 4-bit wait counter increments each MEM cycle. At TIMEOUT without mem_ready: set the timeout flag, drop mem_req, go to DONE.
- DONE:
  - wb_valid is high for exactly one cycle, then go to IDLE.
- Alignment rules:
  - lh, lhu and sh require addr[0]==0.
  - lw and sw require addr[1:0]==0.
  - Byte ops are always aligned.
  - A misaligned access issues no memory request and sets err_misalign.
- Store lanes:
  - sb: wstrb = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - sh: wstrb = 4'b0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - sw: wstrb = 4'b1111; wdata = rs2.
- Load extract:
  - Take the byte or half selected by addr[1:0].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw is the raw word.
- Writeback data and enable:
  - Loads: extracted data.
  - jal and jalr: pc+4, with 32-bit wrap (0xFFFFFFFC gives 0).
  - Branches, stores and unknown opcodes: wb_we=0.
  - All other ops: alu_out.
  - wb_we is forced to 0 when rd==0 or on any error.
- wb_rd always echoes the captured rd.

## Timing
- Reset values: state IDLE; ready_out=1; counter=0. Every other output is 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_we, wb_rd, wb_data and both err flags.
- Non-memory or misaligned op: accepted at edge N, wb_valid high in cycle N+1.
- Memory op:
  - Accepted at edge N; mem_req is high from cycle N+1.
  - mem_ready high in cycle M: mem_req drops at M+1 and wb_valid is high in cycle M+1.
  - Minimum load-to-writeback latency is 2 cycles.
- mem_ready is ignored outside MEM.
- valid_in is ignored while ready_out=0. Upstream must hold its record.
- rst asserted in any state returns to IDLE on the next edge:
  - mem_req and wb_valid are low the following cycle.
  - An in-flight request is abandoned without writeback.

## Test plan
- addi, rd=5, alu_out=0x1234 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, mem_req=0.
- lb, alu_out=0x103, mem_rdata=0x80FF0000, mem_ready after 2 wait cycles -> mem_addr=0x100, mem_req high for 3 cycles, wb_data=0xFFFFFF80. Repeat with lbu -> wb_data=0x00000080.
- sh, alu_out=0x202, rs2=0xABCD1234 -> mem_we=1, mem_wstrb=4'b1100, mem_wdata=0x12341234, wb_we=0.
- lw with alu_out=0x102 -> no mem_req, err_misalign=1, wb_we=0. Follow with a back-to-back valid addi, which is accepted in the next IDLE.
- jal, pc=0x40, rd=1 -> wb_data=0x44. Same with rd=0 -> wb_we=0.
- lw with mem_ready held low -> err_timeout after TIMEOUT cycles, wb_we=0. Separately, assert rst mid-MEM -> mem_req=0 and no wb_valid on the next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store beat on the data-memory handshake,
// formats load data and presents one writeback record per accepted instruction.
module mem_stage #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [5:0]       instr_in,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [WIDTH-1:0] rs2,
   input  logic [4:0]       rd,
   input  logic [31:0]      pc,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   input  logic [31:0]      mem_rdata,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             err_misalign,
   output logic             err_timeout
);
   localparam logic [5:0] i_lui  = 6'd0,  i_auipc = 6'd1,  i_jal  = 6'd2,  i_jalr = 6'd3;
   localparam logic [5:0] i_beq  = 6'd4,  i_bne   = 6'd5,  i_blt  = 6'd6,  i_bge  = 6'd7;
   localparam logic [5:0] i_bltu = 6'd8,  i_bgeu  = 6'd9;
   localparam logic [5:0] i_lb   = 6'd10, i_lh    = 6'd11, i_lw   = 6'd12, i_lbu  = 6'd13;
   localparam logic [5:0] i_lhu  = 6'd14, i_sb    = 6'd15, i_sh   = 6'd16, i_sw   = 6'd17;
   localparam logic [5:0] i_addi = 6'd18, i_and   = 6'd36;

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

   typedef struct packed {
      logic [5:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] d;
      logic [4:0]       rd;
      logic [31:0]      pc;
   } rec_t;

   state_t           state;
   rec_t             rec_q, cur;
   logic [3:0]       cnt;
   logic             is_load, is_store, misalign;
   logic [3:0]       strb;
   logic [31:0]      wdata, lane_b, lane_h;
   logic [WIDTH-1:0] res_d;
   logic             res_we;

   assign ready_out = (state == S_IDLE);

   // Decode from the live inputs while idle, from the captured record otherwise.
   always_comb begin
      cur = rec_q;
      if (state == S_IDLE) begin
         cur.op = instr_in;
         cur.a  = alu_out;
         cur.d  = rs2;
         cur.rd = rd;
         cur.pc = pc;
      end
      is_load  = cur.op inside {i_lb, i_lh, i_lw, i_lbu, i_lhu};
      is_store = cur.op inside {i_sb, i_sh, i_sw};
      misalign = 1'b0;
      strb     = 4'b0000;
      wdata    = 32'd0;
      case (cur.op)
         i_lh, i_lhu: misalign = cur.a[0];
         i_lw:        misalign = |cur.a[1:0];
         i_sb: begin
            strb  = 4'b0001 << cur.a[1:0];
            wdata = {4{cur.d[7:0]}};
         end
         i_sh: begin
            misalign = cur.a[0];
            strb     = 4'b0011 << cur.a[1:0];
            wdata    = {2{cur.d[15:0]}};
         end
         i_sw: begin
            misalign = |cur.a[1:0];
            strb     = 4'b1111;
            wdata    = cur.d[31:0];
         end
         default: ;
      endcase

      lane_b = mem_rdata >> {cur.a[1:0], 3'b000};
      lane_h = mem_rdata >> {cur.a[1], 4'b0000};
      res_d  = cur.a;
      res_we = 1'b0;
      case (cur.op)
         i_lb:        begin res_d = {{(WIDTH-8){lane_b[7]}}, lane_b[7:0]};    res_we = 1'b1; end
         i_lbu:       begin res_d = {{(WIDTH-8){1'b0}}, lane_b[7:0]};         res_we = 1'b1; end
         i_lh:        begin res_d = {{(WIDTH-16){lane_h[15]}}, lane_h[15:0]}; res_we = 1'b1; end
         i_lhu:       begin res_d = {{(WIDTH-16){1'b0}}, lane_h[15:0]};       res_we = 1'b1; end
         i_lw:        begin res_d = WIDTH'(mem_rdata);                        res_we = 1'b1; end
         i_jal, i_jalr: begin res_d = WIDTH'(cur.pc + 32'd4);                 res_we = 1'b1; end
         default:     res_we = cur.op inside {i_lui, i_auipc, [i_addi:i_and]};
      endcase
      if (cur.rd == 5'd0 || misalign) res_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         rec_q        <= '0;
         cnt          <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wstrb    <= '0;
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (valid_in) begin
               rec_q <= cur;
               cnt   <= '0;
               if ((is_load || is_store) && !misalign) begin
                  state     <= S_MEM;
                  mem_req   <= 1'b1;
                  mem_we    <= is_store;
                  mem_addr  <= {cur.a[31:2], 2'b00};
                  mem_wdata <= wdata;
                  mem_wstrb <= strb;
               end else begin
                  state        <= S_DONE;
                  wb_valid     <= 1'b1;
                  wb_we        <= res_we;
                  wb_rd        <= cur.rd;
                  wb_data      <= res_d;
                  err_misalign <= misalign;
               end
            end
            S_MEM: begin
               if (mem_ready || cnt == 4'(TIMEOUT - 1)) begin
                  state       <= S_DONE;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  mem_wstrb   <= '0;
                  wb_valid    <= 1'b1;
                  wb_we       <= res_we && mem_ready;
                  wb_rd       <= cur.rd;
                  wb_data     <= res_d;
                  err_timeout <= !mem_ready;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_DONE: begin
               state        <= S_IDLE;
               wb_valid     <= 1'b0;
               err_misalign <= 1'b0;
               err_timeout  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for ALU pass-through,
// loads/stores, misalignment, timeout and reset during a request.
module tb_mem_stage;
   localparam logic [5:0] I_JAL = 6'd2, I_JALR = 6'd3, I_BEQ = 6'd4;
   localparam logic [5:0] I_LB = 6'd10, I_LH = 6'd11, I_LW = 6'd12, I_LBU = 6'd13;
   localparam logic [5:0] I_SB = 6'd15, I_SH = 6'd16, I_SW = 6'd17, I_ADDI = 6'd18;
   localparam logic [5:0] I_BAD = 6'd63;

   logic        clk = 1'b0, rst = 1'b1;
   logic        valid_in = 1'b0, ready_out;
   logic [5:0]  instr_in = '0;
   logic [31:0] alu_out = '0, rs2 = '0, pc = '0;
   logic [4:0]  rd = '0;
   logic        mem_req, mem_we, mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wstrb;
   logic        wb_valid, wb_we, err_misalign, err_timeout;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_chk = 0, n_err = 0;
   int req_cyc;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_strb;
   logic        seen_we;

   mem_stage #(.WIDTH(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
      .instr_in(instr_in), .alu_out(alu_out), .rs2(rs2), .rd(rd), .pc(pc),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic [31:0] p);
      valid_in = 1'b1; instr_in = op; alu_out = a; rs2 = d; rd = r; pc = p;
      step();
      valid_in = 1'b0;
   endtask

   // Runs a memory op, raising mem_ready after 'waits' request cycles; ends in the writeback cycle.
   task automatic mem_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic [31:0] rdata, input int waits);
      mem_rdata = rdata;
      issue(op, a, d, r, 32'h0);
      req_cyc = 0;
      seen_addr = mem_addr; seen_wdata = mem_wdata; seen_strb = mem_wstrb; seen_we = mem_we;
      for (int i = 0; i < 40 && mem_req; i++) begin
         req_cyc++;
         mem_ready = (i == waits);
         step();
         mem_ready = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=%0d exp=0", 1);
      $fatal(1, "watchdog");
   end

   initial begin
      step(); step();
      chk("rst_ready", ready_out, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_wbv", wb_valid, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_err", {err_misalign, err_timeout, mem_wstrb}, 0);
      rst = 1'b0;
      step();

      issue(I_ADDI, 32'h1234, 32'h0, 5'd5, 32'h0);
      chk("addi_wbv", wb_valid, 1);
      chk("addi_we", wb_we, 1);
      chk("addi_rd", wb_rd, 5);
      chk("addi_data", wb_data, 32'h1234);
      chk("addi_req", mem_req, 0);
      chk("addi_busy", ready_out, 0);
      step();
      chk("addi_pulse", wb_valid, 0);
      chk("addi_idle", ready_out, 1);

      mem_op(I_LB, 32'h103, 32'h0, 5'd6, 32'h80FF0000, 2);
      chk("lb_addr", seen_addr, 32'h100);
      chk("lb_we", seen_we, 0);
      chk("lb_reqcyc", req_cyc, 3);
      chk("lb_wbv", wb_valid, 1);
      chk("lb_data", wb_data, 32'hFFFFFF80);
      chk("lb_wbwe", wb_we, 1);
      step();

      mem_op(I_LBU, 32'h103, 32'h0, 5'd6, 32'h80FF0000, 2);
      chk("lbu_data", wb_data, 32'h00000080);
      chk("lbu_reqcyc", req_cyc, 3);
      step();

      mem_op(I_LH, 32'h102, 32'h0, 5'd9, 32'h80FF0000, 0);
      chk("lh_reqcyc", req_cyc, 1);
      chk("lh_data", wb_data, 32'hFFFF80FF);
      chk("lh_rd", wb_rd, 9);
      step();

      mem_op(I_SH, 32'h202, 32'hABCD1234, 5'd3, 32'h0, 0);
      chk("sh_we", seen_we, 1);
      chk("sh_strb", seen_strb, 4'b1100);
      chk("sh_wdata", seen_wdata, 32'h12341234);
      chk("sh_addr", seen_addr, 32'h200);
      chk("sh_wbwe", wb_we, 0);
      chk("sh_wbv", wb_valid, 1);
      step();

      mem_op(I_SB, 32'h101, 32'h00000055, 5'd3, 32'h0, 1);
      chk("sb_strb", seen_strb, 4'b0010);
      chk("sb_wdata", seen_wdata, 32'h55555555);
      step();

      mem_op(I_SW, 32'h300, 32'hDEADBEEF, 5'd3, 32'h0, 0);
      chk("sw_strb", seen_strb, 4'b1111);
      chk("sw_wdata", seen_wdata, 32'hDEADBEEF);
      step();

      // Misaligned lw, then an addi held valid while the stage is busy.
      issue(I_LW, 32'h102, 32'h0, 5'd4, 32'h0);
      chk("mis_req", mem_req, 0);
      chk("mis_wbv", wb_valid, 1);
      chk("mis_err", err_misalign, 1);
      chk("mis_we", wb_we, 0);
      valid_in = 1'b1; instr_in = I_ADDI; alu_out = 32'h77; rd = 5'd7;
      step();
      chk("b2b_idle", ready_out, 1);
      chk("b2b_nowb", wb_valid, 0);
      step();
      valid_in = 1'b0;
      chk("b2b_wbv", wb_valid, 1);
      chk("b2b_data", wb_data, 32'h77);
      chk("b2b_rd", wb_rd, 7);
      chk("b2b_err", err_misalign, 0);
      step();

      issue(I_JAL, 32'h0, 32'h0, 5'd1, 32'h40);
      chk("jal_data", wb_data, 32'h44);
      chk("jal_we", wb_we, 1);
      step();
      issue(I_JAL, 32'h0, 32'h0, 5'd0, 32'h40);
      chk("jal_rd0_we", wb_we, 0);
      chk("jal_rd0_v", wb_valid, 1);
      step();
      issue(I_JALR, 32'h0, 32'h0, 5'd2, 32'hFFFFFFFC);
      chk("jalr_wrap", wb_data, 32'h0);
      step();
      issue(I_BEQ, 32'h1, 32'h0, 5'd2, 32'h0);
      chk("beq_we", wb_we, 0);
      step();
      issue(I_BAD, 32'h1, 32'h0, 5'd3, 32'h0);
      chk("bad_we", wb_we, 0);
      chk("bad_v", wb_valid, 1);
      step();

      mem_op(I_LW, 32'h400, 32'h0, 5'd8, 32'h12345678, 99);
      chk("to_reqcyc", req_cyc, 15);
      chk("to_wbv", wb_valid, 1);
      chk("to_err", err_timeout, 1);
      chk("to_we", wb_we, 0);
      step();
      chk("to_clr", err_timeout, 0);

      issue(I_LW, 32'h500, 32'h0, 5'd8, 32'h0);
      chk("rm_req", mem_req, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rm_req_lo", mem_req, 0);
      chk("rm_wbv_lo", wb_valid, 0);
      chk("rm_ready", ready_out, 1);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("rm_nowb", wb_valid, 0);
      chk("rm_noreq", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
